// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the LSU data-port memory responder.
// Imported by the responder top and its interface.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_ACCESS,
    RSP_ACK
  } dmem_rsp_state_e;

  localparam logic [31:0] DMEM_ERR_RDATA = 32'h0;

  // Bundled request fields, captured once req_s is seen in IDLE.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // A misaligned address, or an offset past the array, is an error.
  // The offset is an unsigned 32-bit difference, so an address below
  // the base wraps to a large value and is caught as out of range.
  function automatic logic dmem_addr_err(input logic [1:0]  addr_lsb,
                                         input logic [31:0] offset,
                                         input logic [32:0] span_bytes);
    return (addr_lsb != 2'b00) || ({1'b0, offset} >= span_bytes);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Four-phase bundled-data LSU data port.
// The master is the self-timed core; the slave is the memory responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata, err);

endinterface

// File: rtl/dmem_responder_req_synchronizer.sv
// Multi-flop synchronizer that brings an asynchronous request into the clk_i domain.
// Also used by the instruction-side responder.
module req_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the LSU data port: four-phase handshake in,
// word read or byte-masked write into an internal synchronous SRAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic            req_s;
  dmem_rsp_state_e state;
  logic [3:0]      cnt;
  dmem_req_t       req_q;
  logic            ack_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [31:0]     mem [MEM_WORDS];

  logic [31:0]     offset;
  logic [IDX_W-1:0] idx;
  logic            acc_err;
  logic            mem_we;

  req_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.req),
    .q_o    (req_s)
  );

  assign offset  = req_q.addr - BASE_ADDR;
  assign idx     = offset[IDX_W+1:2];
  assign acc_err = dmem_addr_err(req_q.addr[1:0], offset, SPAN_BYTES);
  assign mem_we  = (state == RSP_ACCESS) && req_q.we && !acc_err;

  // NOTE: every sequential assignment is non-blocking so all registers
  // update from the same pre-edge values and simulation matches synthesis.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RSP_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (req_s) begin
            req_q <= '{we: bus.we, be: bus.be, addr: bus.addr, wdata: bus.wdata};
            cnt   <= CNT_INIT;
            state <= (WAIT_CYCLES > 0) ? RSP_WAIT : RSP_ACCESS;
          end
        end
        RSP_WAIT: begin
          if (cnt == 4'd0) begin
            state <= RSP_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RSP_ACCESS: begin
          err_q <= acc_err;
          if (acc_err) begin
            rdata_q <= DMEM_ERR_RDATA;
          end else if (!req_q.we) begin
            rdata_q <= mem[idx];
          end
          ack_q <= 1'b1;
          state <= RSP_ACK;
        end
        RSP_ACK: begin
          // rdata/err stay put after the return-to-zero until the next access.
          if (!req_s) begin
            ack_q <= 1'b0;
            state <= RSP_IDLE;
          end
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto SRAM; its contents are
  // undefined until written.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_q.be[k]) begin
          mem[idx][8*k +: 8] <= req_q.wdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder: a default build and a
// zero-wait-state build with a non-zero base address.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(
    .MEM_WORDS   (1024),
    .BASE_ADDR   (32'h0000_0000),
    .SYNC_STAGES (2),
    .WAIT_CYCLES (1)
  ) dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0.slave)
  );

  dmem_responder #(
    .MEM_WORDS   (1024),
    .BASE_ADDR   (32'h0000_0100),
    .SYNC_STAGES (2),
    .WAIT_CYCLES (0)
  ) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_rise;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      bus0.req = req; bus0.we = we; bus0.be = be; bus0.addr = addr; bus0.wdata = wdata;
    end else begin
      bus1.req = req; bus1.we = we; bus1.be = be; bus1.addr = addr; bus1.wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? bus0.ack : bus1.ack;
  endfunction

  // Drive one full four-phase transaction; latencies count edges from the
  // first edge that samples the new req level. A stuck handshake stops at 50.
  task automatic run_txn(input int sel, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int rise, output int fall);
    @(negedge clk);
    drive(sel, 1'b1, we, be, addr, wdata);
    rise = 0;
    do begin
      @(posedge clk); #1; rise++;
    end while (ack_of(sel) !== 1'b1 && rise < 50);
    rdata = (sel == 0) ? bus0.rdata : bus1.rdata;
    err   = (sel == 0) ? bus0.err   : bus1.err;
    @(negedge clk);
    drive(sel, 1'b0, we, be, addr, wdata);
    fall = 0;
    do begin
      @(posedge clk); #1; fall++;
    end while (ack_of(sel) !== 1'b0 && fall < 50);
  endtask

  vec_t        vecs [$];
  logic [31:0] rd;
  logic        er;
  int          rise, fall;

  initial begin
    // sel we  be     addr          wdata          exp_rdata      err   rise
    vecs.push_back('{0, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hCAFE_BABE, 1'b0, 5});
    vecs.push_back('{0, 1'b1, 4'h5, 32'h0000_0010, 32'h1122_3344, 32'hCAFE_BABE, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hCA22_BA44, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hCA22_BA44, 1'b0, 5});
    vecs.push_back('{0, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hCA22_BA44, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hCA22_BA44, 1'b0, 5});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h0000_0000, 32'h5A5A_5A5A, 32'hCA22_BA44, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 5});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A, 1'b0, 5});
    vecs.push_back('{0, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h5A5A_5A5A, 1'b0, 5});
    vecs.push_back('{0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 1'b0, 5});
    vecs.push_back('{1, 1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b0, 4});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'h1234_5678, 1'b0, 4});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h0000_00FC, 32'h0,         32'h0000_0000, 1'b1, 4});
    vecs.push_back('{1, 1'b0, 4'hF, 32'h0000_1100, 32'h0,         32'h0000_0000, 1'b1, 4});

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset ack0",   32'(bus0.ack),   32'h0);
    check("reset rdata0", bus0.rdata,      32'h0);
    check("reset err0",   32'(bus0.err),   32'h0);
    check("reset ack1",   32'(bus1.ack),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].sel, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
              rd, er, rise, fall);
      check($sformatf("v%0d rdata", i), rd,          vecs[i].exp_rdata);
      check($sformatf("v%0d err", i),   32'(er),     32'(vecs[i].exp_err));
      check($sformatf("v%0d rise", i),  32'(rise),   32'(vecs[i].exp_rise));
      check($sformatf("v%0d fall", i),  32'(fall),   32'd3);
    end

    // Reset while a write to 0x10 sits in WAIT: no partial write may land.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst in wait ack", 32'(bus0.ack), 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, er, rise, fall);
    check("after rst rdata", rd,         32'hCA22_BA44);
    check("after rst err",   32'(er),    32'h0);
    check("after rst rise",  32'(rise),  32'd5);

    // Reset while ACK is high drops ack and clears the response at once.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0);
    rise = 0;
    do begin
      @(posedge clk); #1; rise++;
    end while (bus0.ack !== 1'b1 && rise < 50);
    check("pre-rst ack",    32'(bus0.ack), 32'h1);
    check("pre-rst rdata",  bus0.rdata,    32'h0BAD_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst in ack ack",   32'(bus0.ack), 32'h0);
    check("rst in ack rdata", bus0.rdata,    32'h0);
    check("rst in ack err",   32'(bus0.err), 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle after rst ack", 32'(bus0.ack), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
